uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 8'd16, SHALL set sample ticks per bit; legal values are even numbers 4..254.
REQ-002 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 baud_div  input  16  tick divider; one sample tick SHALL occur every baud_div+1 clocks.
REQ-005 rx_i  input  1  asynchronous serial line, idle high.
REQ-006 parity  input  2  parity mode: 0 none, 1 even, 2 and 3 odd.
REQ-007 stop2  input  1  1 = two stop bits expected, 0 = one stop bit.
REQ-008 data_o  output  8  received byte.
REQ-009 valid_o  output  1  data_o and error flags valid; held until accepted.
REQ-010 ready_i  input  1  consumer accepts on cycles where valid_o && ready_i.
REQ-011 parity_err_o  output  1  parity mismatch for the byte on data_o.
REQ-012 frame_err_o  output  1  a stop bit was sampled low for the byte on data_o.
REQ-013 overrun_o  output  1  one-cycle pulse when a completed byte is dropped.
REQ-014 busy_o  output  1  high while the FSM is not in S_IDLE.

Function
REQ-015 Tick generator: 16-bit down-counter; at 0 SHALL reload baud_div and pulse tick for one clock; otherwise decrement. A baud_div change SHALL take effect at the next reload.
REQ-016 rx_i SHALL pass through a two-flop synchronizer (reset value 1); all sampling SHALL use the synchronized value rxs.
REQ-017 FSM states S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2. The FSM and the sample counter os SHALL advance only on tick.
REQ-018 S_IDLE: on tick with rxs==0, go to S_START with os=OVERSAMPLE/2-1.
REQ-019 S_START: decrement os. At os==0, if rxs==0 go to S_DATA with os=OVERSAMPLE-1, bit count 0. If rxs==1 (false start), return to S_IDLE with no output.
REQ-020 S_DATA: decrement os. At os==0, shift rxs in LSB-first (sh={rxs,sh[7:1]}) and reload os=OVERSAMPLE-1. After the 8th bit, go to S_PAR if parity!=0, else S_STOP1.
REQ-021 S_PAR: at os==0, sample the parity bit p. Error SHALL be p!=^sh for even and p!=~^sh for odd. Then go to S_STOP1 with os reloaded.
REQ-022 S_STOP1: at os==0, sample; a low sample sets the frame error. If stop2, go to S_STOP2 with os reloaded; else complete.
REQ-023 S_STOP2: at os==0, sample; a low sample sets the frame error; complete.
REQ-024 Completion SHALL return the FSM to S_IDLE at mid-stop-bit on the same tick, so the next start edge can be detected immediately.
REQ-025 Delivery: on the completion tick, if valid_o==0 or ready_i==1, the next clock SHALL load data_o, parity_err_o and frame_err_o and set valid_o=1 (latency 1 clock after the final stop sample).
REQ-026 If completion occurs while valid_o==1 and ready_i==0, the new byte SHALL be dropped, the held output SHALL be unchanged, and overrun_o SHALL pulse for 1 clock.
REQ-027 On valid_o && ready_i with no simultaneous completion, valid_o SHALL clear on the next clock; data_o SHALL retain its value.
REQ-028 Framing and parity errors SHALL NOT suppress delivery; the byte SHALL be delivered with its flags.
REQ-029 parity==0 SHALL force parity_err_o=0 for that byte.
REQ-030 A line held low (break) SHALL produce byte 0x00 with frame_err_o=1, then wait in S_IDLE sampling a low line. It SHALL NOT re-trigger until rxs has returned high for at least one tick.

Reset
REQ-031 Reset values: state S_IDLE, os 0, tick counter 0, synchronizer flops 1, data_o 8'h00, valid_o 0, parity_err_o 0, frame_err_o 0, overrun_o 0, busy_o 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no valid_o. Reset SHALL take priority over tick and over the handshake.

Verification
REQ-033 baud_div=0, OVERSAMPLE=16, parity=0, stop2=0; drive 0xA5 at 16 clocks/bit, ready_i=1 -> data_o=0xA5, valid_o for 1 clock, both error flags 0.
REQ-034 parity=1; send 0x3C with parity bit 1 -> data_o=0x3C, parity_err_o=1. Resend with parity bit 0 -> parity_err_o=0. Repeat with parity=2 and the expected flags inverted.
REQ-035 Send 0x55 with the stop bit driven 0 -> data_o=0x55, frame_err_o=1. With stop2=1, drive the second stop bit 0 -> frame_err_o=1.
REQ-036 Low glitch of 4 ticks on an idle line -> FSM returns to S_IDLE, valid_o stays 0, busy_o pulses only.
REQ-037 ready_i=0; send 0x11 then 0x22 back-to-back -> data_o stays 0x11, overrun_o pulses once. Raise ready_i -> valid_o clears.
REQ-038 Assert rst mid-data-bit 4 of a frame -> all outputs at reset values. A following frame 0x81 -> data_o=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver with oversampled bit timing, optional parity and one or two
// stop bits. Received bytes are presented on a valid/ready output port.
//
// Handshake: a byte transfers on every clock where valid_o && ready_i are both
// high. While valid_o is high and ready_i is low, data_o and the error flags
// hold steady. A byte that completes while the port is still holding an
// unaccepted byte is dropped and overrun_o pulses for one clock.
module uart_rx #(
  parameter logic [7:0] OVERSAMPLE = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        rx_i,
  input  logic [1:0]  parity,
  input  logic        stop2,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        busy_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP1 = 3'd4,
    S_STOP2 = 3'd5
  } state_t;

  localparam logic [7:0] OS_LAST   = OVERSAMPLE - 8'd1;
  localparam logic [7:0] HALF_LAST = (OVERSAMPLE >> 1) - 8'd1;

  state_t      state, state_d;
  logic [15:0] tick_cnt;
  logic        tick;
  logic        rx_s1, rxs;
  logic [7:0]  os, os_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  sh, sh_d;
  logic        perr_acc, perr_d;
  logic        ferr_acc, ferr_d;
  logic        complete;
  logic        armed;
  logic        load, drop;

  assign tick = (tick_cnt == 16'd0);

  // Sample-tick divider: reload on zero so a new baud_div lands at the next reload.
  always_ff @(posedge clk) begin
    if (rst)        tick_cnt <= 16'd0;
    else if (tick)  tick_cnt <= baud_div;
    else            tick_cnt <= tick_cnt - 16'd1;
  end

  // Two-flop synchronizer on the asynchronous line, idle-high reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rxs   <= rx_s1;
    end
  end

  // A break leaves the line low after completion; only re-arm start detection
  // once the line has been seen high on a tick.
  always_ff @(posedge clk) begin
    if (rst)              armed <= 1'b0;
    else if (complete)    armed <= rxs;
    else if (tick && rxs) armed <= 1'b1;
  end

  // State register plus the per-frame datapath registers it steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      os       <= 8'd0;
      bit_cnt  <= 3'd0;
      sh       <= 8'd0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      state    <= state_d;
      os       <= os_d;
      bit_cnt  <= bit_cnt_d;
      sh       <= sh_d;
      perr_acc <= perr_d;
      ferr_acc <= ferr_d;
    end
  end

  // Next-state logic: everything advances only on a sample tick.
  always_comb begin
    state_d   = state;
    os_d      = os;
    bit_cnt_d = bit_cnt;
    sh_d      = sh;
    perr_d    = perr_acc;
    ferr_d    = ferr_acc;
    complete  = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rxs && armed) begin
            state_d = S_START;
            os_d    = HALF_LAST;
          end
        end
        S_START: begin
          if (os == 8'd0) begin
            if (!rxs) begin
              state_d   = S_DATA;
              os_d      = OS_LAST;
              bit_cnt_d = 3'd0;
              perr_d    = 1'b0;
              ferr_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            os_d = os - 8'd1;
          end
        end
        S_DATA: begin
          if (os == 8'd0) begin
            sh_d = {rxs, sh[7:1]};
            os_d = OS_LAST;
            if (bit_cnt == 3'd7) state_d = (parity != 2'd0) ? S_PAR : S_STOP1;
            else                 bit_cnt_d = bit_cnt + 3'd1;
          end else begin
            os_d = os - 8'd1;
          end
        end
        S_PAR: begin
          if (os == 8'd0) begin
            perr_d  = (parity == 2'd1) ? (rxs != ^sh) : (rxs != ~^sh);
            os_d    = OS_LAST;
            state_d = S_STOP1;
          end else begin
            os_d = os - 8'd1;
          end
        end
        S_STOP1: begin
          if (os == 8'd0) begin
            if (!rxs) ferr_d = 1'b1;
            if (stop2) begin
              state_d = S_STOP2;
              os_d    = OS_LAST;
            end else begin
              state_d  = S_IDLE;
              complete = 1'b1;
            end
          end else begin
            os_d = os - 8'd1;
          end
        end
        S_STOP2: begin
          if (os == 8'd0) begin
            if (!rxs) ferr_d = 1'b1;
            state_d  = S_IDLE;
            complete = 1'b1;
          end else begin
            os_d = os - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode: busy/debug state and whether a finished byte is kept or dropped.
  always_comb begin
    busy_o  = (state != S_IDLE);
    state_o = state;
    load    = complete && (!valid_o || ready_i);
    drop    = complete && valid_o && !ready_i;
  end

  // Output port registers: load on completion, clear valid on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o       <= 8'h00;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= drop;
      if (load) begin
        data_o       <= sh_d;
        parity_err_o <= perr_d;
        frame_err_o  <= ferr_d;
        valid_o      <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven serially, expected {parity_err,
// frame_err, data} words are queued by the driver and popped by a monitor
// whenever the output port hands over a byte.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_i;
  logic [1:0]  parity;
  logic        stop2;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        busy_o;
  logic [2:0]  state_o;

  logic [9:0]  exp_q[$];
  logic [9:0]  exp_w;
  int          total = 0;
  int          bad = 0;
  int          ovr_seen = 0;
  int          bit_clks = 16;

  uart_rx #(.OVERSAMPLE(8'd16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx_i(rx_i), .parity(parity),
    .stop2(stop2), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o), .state_o(state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // reference model: parity judged by total count of ones, frame by stop levels
  function automatic logic [9:0] model(input logic [7:0] b, input logic [1:0] pm,
                                       input logic pbit, input logic s1,
                                       input logic s2, input logic two);
    int  ones;
    logic perr, ferr;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    ones += int'(pbit);
    if (pm == 2'd0)      perr = 1'b0;
    else if (pm == 2'd1) perr = (ones % 2) != 0;
    else                 perr = (ones % 2) != 1;
    ferr = !s1 || (two && !s2);
    return {perr, ferr, b};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive_level(input logic v, input int n);
    rx_i = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] pm, input logic pbit,
                            input logic s1, input logic s2, input logic two,
                            input logic push);
    parity = pm;
    stop2  = two;
    if (push) exp_q.push_back(model(b, pm, pbit, s1, s2, two));
    drive_level(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) drive_level(b[i], bit_clks);
    if (pm != 2'd0) drive_level(pbit, bit_clks);
    drive_level(s1, bit_clks);
    if (two) drive_level(s2, bit_clks);
    rx_i = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] b, input int gap);
    send_frame(b, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_level(1'b1, gap);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun_o) ovr_seen++;
      if (valid_o && ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: got data=%0h perr=%0b ferr=%0b want none",
                   data_o, parity_err_o, frame_err_o);
        end else begin
          exp_w = exp_q.pop_front();
          if ({parity_err_o, frame_err_o, data_o} !== exp_w) begin
            bad++;
            $display("FAIL byte: got data=%0h perr=%0b ferr=%0b want data=%0h perr=%0b ferr=%0b",
                     data_o, parity_err_o, frame_err_o, exp_w[7:0], exp_w[9], exp_w[8]);
          end
        end
      end
    end
  end

  // main sequence
  initial begin
    int busy_hi;
    int ovr_base;
    rst = 1'b1; baud_div = 16'd0; rx_i = 1'b1; parity = 2'd0; stop2 = 1'b0; ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data", {24'd0, data_o}, 32'h00);
    check("rst_flags", {27'd0, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o}, 32'h0);
    check("rst_state", {29'd0, state_o}, 32'd0);
    rst = 1'b0;
    drive_level(1'b1, 10);

    // basic byte
    send_ok(8'hA5, 40);

    // parity even then odd, both parity bit values
    send_frame(8'h3C, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); drive_level(1'b1, 20);
    send_frame(8'h3C, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); drive_level(1'b1, 20);
    send_frame(8'h3C, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); drive_level(1'b1, 20);
    send_frame(8'h3C, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); drive_level(1'b1, 20);
    send_frame(8'h3C, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); drive_level(1'b1, 20);

    // framing errors, one and two stop bits
    send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); drive_level(1'b1, 20);
    send_frame(8'h55, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); drive_level(1'b1, 20);
    send_frame(8'h96, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); drive_level(1'b1, 20);

    // short low glitch: false start only
    busy_hi = 0;
    rx_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (busy_o) busy_hi = 1;
    end
    rx_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); if (busy_o) busy_hi = 1;
    end
    @(posedge clk); #1;
    check("glitch_busy_seen", busy_hi, 1);
    check("glitch_idle", {28'd0, busy_o, state_o}, 32'd0);
    check("glitch_no_valid", {31'd0, valid_o}, 32'd0);

    // overrun: second byte dropped while first is held
    parity = 2'd0; stop2 = 1'b0;
    ovr_base = ovr_seen;
    ready_i = 1'b0;
    send_frame(8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_level(1'b1, 20);
    check("held_valid", {31'd0, valid_o}, 32'd1);
    check("held_data", {24'd0, data_o}, 32'h11);
    check("overrun_pulses", ovr_seen - ovr_base, 1);
    ready_i = 1'b1;
    @(posedge clk); #1;
    check("valid_cleared", {31'd0, valid_o}, 32'd0);
    check("data_retained", {24'd0, data_o}, 32'h11);
    drive_level(1'b1, 10);

    // reset in the middle of data bit 4
    rx_i = 1'b0;
    drive_level(1'b0, bit_clks);
    for (int i = 0; i < 4; i++) drive_level(i[0], bit_clks);
    drive_level(1'b0, bit_clks / 2);
    rst = 1'b1;
    rx_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_data", {24'd0, data_o}, 32'h00);
    check("midrst_flags", {27'd0, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o}, 32'h0);
    check("midrst_state", {29'd0, state_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_level(1'b1, 40);
    send_ok(8'h81, 40);

    // break: long low line gives one 0x00 with frame error and no retrigger
    parity = 2'd0; stop2 = 1'b0;
    exp_q.push_back(model(8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    drive_level(1'b0, 14 * bit_clks);
    check("break_idle", {28'd0, busy_o, state_o}, 32'd0);
    drive_level(1'b1, 40);
    send_ok(8'h5A, 40);

    // slower tick: one tick every two clocks
    baud_div = 16'd1; bit_clks = 32;
    drive_level(1'b1, 10);
    send_frame(8'hC3, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); drive_level(1'b1, 40);
    send_ok(8'h7E, 40);
    baud_div = 16'd0; bit_clks = 16;
    drive_level(1'b1, 10);

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic [1:0] pm;
      logic pb, s1, s2, two;
      b   = 8'($urandom_range(0, 255));
      pm  = 2'($urandom_range(0, 3));
      pb  = 1'($urandom_range(0, 1));
      s1  = ($urandom_range(0, 5) != 0);
      s2  = ($urandom_range(0, 5) != 0);
      two = 1'($urandom_range(0, 1));
      send_frame(b, pm, pb, s1, s2, two, 1'b1);
      drive_level(1'b1, $urandom_range(4, 40));
    end

    // drain and final report
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("queue_drained", exp_q.size(), 0);
    check("overrun_total", ovr_seen, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
